nonce_scan_ctrl: RTL and testbench

- Autonomous nonce-sweep engine that drives one register-mapped sha256 core (cs/we/address/write_data/read_data).
- Holds a 16-word message block and substitutes a running nonce into one configurable word.
- For each nonce it hashes the block and reads back the digest, then compares the leading digest words against a target.
- Stops on the first hit, on range exhaustion, on abort or on timeout. This replaces firmware-driven word-by-word control with a full on-chip scan loop.

---
 rtl/nonce_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_nonce_scan_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scan_ctrl.sv
// Nonce sweep engine: loads a 16-word block into a register-mapped sha256 core,
// substitutes a running nonce, reads the digest back and stops on the first digest <= target.
module nonce_scan_ctrl #(
    parameter int BITS         = 32,
    parameter int NONCE_IDX    = 3,
    parameter int DIGEST_WORDS = 8,
    parameter int CMP_WORDS    = 1,
    parameter int TIMEOUT_W    = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         blk_we,
    input  logic [3:0]                   blk_addr,
    input  logic [BITS-1:0]              blk_wdata,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         mode_224,
    input  logic [BITS-1:0]              nonce_start,
    input  logic [BITS-1:0]              nonce_end,
    input  logic [CMP_WORDS*BITS-1:0]    target,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic                         timeout_err,
    output logic [BITS-1:0]              cur_nonce,
    output logic [BITS-1:0]              found_nonce,
    output logic [DIGEST_WORDS*BITS-1:0] digest_o,
    output logic [BITS-1:0]              hash_count,
    output logic                         sha_cs,
    output logic                         sha_we,
    output logic [7:0]                   sha_address,
    output logic [BITS-1:0]              sha_write_data,
    input  logic [BITS-1:0]              sha_read_data
);

    localparam int DW = DIGEST_WORDS * BITS;
    localparam int CW = CMP_WORDS * BITS;
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CTRL, S_SETTLE, S_POLL, S_READ, S_CMP
    } state_t;

    state_t                 state_q, state_d;
    logic [BITS-1:0]        buf_q [16];
    logic [BITS-1:0]        buf_d [16];
    logic [3:0]             idx_q, idx_d;
    logic [TIMEOUT_W-1:0]   to_q, to_d;
    logic                   mode_q, mode_d;
    logic [BITS-1:0]        nend_q, nend_d;
    logic [CW-1:0]          target_q, target_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   found_q, found_d;
    logic                   to_err_q, to_err_d;
    logic [BITS-1:0]        cur_q, cur_d;
    logic [BITS-1:0]        fnonce_q, fnonce_d;
    logic [DW-1:0]          digest_q, digest_d;
    logic [BITS-1:0]        hcnt_q, hcnt_d;
    logic                   hit;

    // Leading CMP_WORDS digest words, word0 most significant, as one unsigned value.
    assign hit = (digest_q[DW-1 -: CW] <= target_q);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (state_q == S_IDLE && blk_we) begin
            buf_d[blk_addr] = blk_wdata;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        to_d           = to_q;
        mode_d         = mode_q;
        nend_d         = nend_q;
        target_d       = target_q;
        busy_d         = busy_q;
        done_d         = done_q;
        found_d        = found_q;
        to_err_d       = to_err_q;
        cur_d          = cur_q;
        fnonce_d       = fnonce_q;
        digest_d       = digest_q;
        hcnt_d         = hcnt_q;
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = 8'h00;
        sha_write_data = '0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mode_d   = mode_224;
                    nend_d   = nonce_end;
                    target_d = target;
                    cur_d    = nonce_start;
                    hcnt_d   = '0;
                    done_d   = 1'b0;
                    found_d  = 1'b0;
                    to_err_d = 1'b0;
                    busy_d   = 1'b1;
                    idx_d    = 4'd0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = 8'h10 + {4'h0, idx_q};
                sha_write_data = (idx_q == 4'(NONCE_IDX)) ? cur_q : buf_q[idx_q];
                idx_d          = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = S_CTRL;
                end
            end
            S_CTRL: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = 8'h08;
                sha_write_data = {{(BITS-3){1'b0}}, ~mode_q, 2'b01};
                state_d        = S_SETTLE;
            end
            S_SETTLE: begin
                to_d    = '0;
                state_d = S_POLL;
            end
            S_POLL: begin
                sha_cs      = 1'b1;
                sha_address = 8'h09;
                if (sha_read_data[0] && sha_read_data[1]) begin
                    to_d    = '0;
                    idx_d   = 4'd0;
                    state_d = S_READ;
                end else begin
                    to_d = to_q + 1'b1;
                    if (to_q == TO_LAST) begin
                        to_err_d = 1'b1;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_READ: begin
                sha_cs      = 1'b1;
                sha_address = 8'h20 + {4'h0, idx_q};
                digest_d[(DIGEST_WORDS-1-int'(idx_q))*BITS +: BITS] = sha_read_data;
                idx_d       = idx_q + 4'd1;
                if (idx_q == 4'(DIGEST_WORDS-1)) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                hcnt_d = hcnt_q + BITS'(1);
                if (hit) begin
                    found_d  = 1'b1;
                    fnonce_d = cur_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (cur_q == nend_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cur_d   = cur_q + BITS'(1);
                    idx_d   = 4'd0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort outranks anything the current state decided, including a hit in CMP.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            found_d  = 1'b0;
            to_err_d = to_err_q;
            fnonce_d = fnonce_q;
            hcnt_d   = hcnt_q;
            cur_d    = cur_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
            idx_q    <= '0;
            to_q     <= '0;
            mode_q   <= 1'b0;
            nend_q   <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            to_err_q <= 1'b0;
            cur_q    <= '0;
            fnonce_q <= '0;
            digest_q <= '0;
            hcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= buf_d[i];
            end
            idx_q    <= idx_d;
            to_q     <= to_d;
            mode_q   <= mode_d;
            nend_q   <= nend_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            to_err_q <= to_err_d;
            cur_q    <= cur_d;
            fnonce_q <= fnonce_d;
            digest_q <= digest_d;
            hcnt_q   <= hcnt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign timeout_err = to_err_q;
    assign cur_nonce   = cur_q;
    assign found_nonce = fnonce_q;
    assign digest_o    = digest_q;
    assign hash_count  = hcnt_q;

endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// Bench for nonce_scan_ctrl: a behavioural sha256 core stub plus a scan-level model
// that predicts every bus write and the end-of-scan results.
module tb_nonce_scan_ctrl;

    localparam int IDX = 0;
    localparam int TW  = 4;
    localparam int DWN = 8;

    localparam logic [31:0] KC [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         blk_we;
    logic [3:0]   blk_addr;
    logic [31:0]  blk_wdata;
    logic         start;
    logic         abort;
    logic         mode_224;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [31:0]  target;
    logic         busy, done, found, timeout_err;
    logic [31:0]  cur_nonce, found_nonce, hash_count;
    logic [255:0] digest_o;
    logic         sha_cs, sha_we;
    logic [7:0]   sha_address;
    logic [31:0]  sha_write_data;
    logic [31:0]  sha_read_data;

    always #5 clk = ~clk;

    nonce_scan_ctrl #(
        .BITS(32), .NONCE_IDX(IDX), .DIGEST_WORDS(DWN), .CMP_WORDS(1), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .blk_we(blk_we), .blk_addr(blk_addr), .blk_wdata(blk_wdata),
        .start(start), .abort(abort), .mode_224(mode_224), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .target(target), .busy(busy), .done(done), .found(found),
        .timeout_err(timeout_err), .cur_nonce(cur_nonce), .found_nonce(found_nonce),
        .digest_o(digest_o), .hash_count(hash_count), .sha_cs(sha_cs), .sha_we(sha_we),
        .sha_address(sha_address), .sha_write_data(sha_write_data), .sha_read_data(sha_read_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Single-block SHA-256/224 compression from the standard IV; h0 lands in the MSBs.
    function automatic logic [255:0] sha_ref(input logic [511:0] blk, input bit is256);
        logic [31:0] w [64];
        logic [31:0] h [8];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        for (int i = 0; i < 8; i++) h[i] = is256 ? IV256[i] : IV224[i];
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KC[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i];
        return r;
    endfunction

    function automatic logic [511:0] pack16(input logic [31:0] arr [16]);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[511 - 32*k -: 32] = arr[k];
        return r;
    endfunction

    // ---------------- sha256 core stub ----------------
    logic [31:0]  core_blk [16];
    logic [255:0] core_dig = '0;
    int           core_pend = 0;
    logic         core_vld = 1'b0;
    bit           stuck = 1'b0;

    always @(posedge clk) begin
        if (sha_cs && sha_we) begin
            if (sha_address[7:4] == 4'h1) core_blk[sha_address[3:0]] <= sha_write_data;
            if (sha_address == 8'h08 && sha_write_data[0]) begin
                core_dig  <= sha_ref(pack16(core_blk), sha_write_data[2]);
                core_pend <= 3;
                core_vld  <= 1'b0;
            end
        end else if (core_pend > 0) begin
            core_pend <= core_pend - 1;
        end else begin
            core_vld <= 1'b1;
        end
    end

    always_comb begin
        sha_read_data = 32'h0;
        if (sha_address == 8'h09)
            sha_read_data = {30'b0, core_vld && !stuck, core_pend == 0};
        else if (sha_address[7:3] == 5'b00100)
            sha_read_data = core_dig[255 - 32*int'(sha_address[2:0]) -: 32];
    end

    // ---------------- scan-level model ----------------
    logic [31:0] mbuf [16];
    logic [31:0] m_start = '0;
    bit          m_mode = 1'b0;

    function automatic logic [511:0] blk_with(input logic [31:0] n);
        logic [31:0] arr [16];
        for (int k = 0; k < 16; k++) arr[k] = (k == IDX) ? n : mbuf[k];
        return pack16(arr);
    endfunction

    task automatic model(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t, input bit mode,
                         output bit mfound, output logic [31:0] mcnt, output logic [31:0] mcur,
                         output logic [255:0] mdig);
        logic [31:0] n = s;
        mfound = 1'b0;
        mcnt   = 0;
        for (int i = 0; i < 64; i++) begin
            mdig = sha_ref(blk_with(n), !mode);
            mcnt++;
            if (mdig[255:224] <= t) begin mfound = 1'b1; break; end
            if (n == e) break;
            n++;
        end
        mcur = n;
    endtask

    // Bus monitor: every core write must match the write sequence implied by the scan.
    int          wr_cnt = 0;
    int          poll_cnt = 0;
    logic [31:0] last_ctrl = '0;

    initial begin
        logic [31:0] n, ed;
        logic [7:0]  ea;
        int          k;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (!busy && start && !abort) begin
                    wr_cnt   = 0;
                    poll_cnt = 0;
                end
                if (sha_cs && sha_we) begin
                    n = m_start + 32'(wr_cnt / 17);
                    k = wr_cnt % 17;
                    if (k == 16) begin
                        ea = 8'h08;
                        ed = m_mode ? 32'h1 : 32'h5;
                        last_ctrl = sha_write_data;
                    end else begin
                        ea = 8'h10 + 8'(k);
                        ed = (k == IDX) ? n : mbuf[k];
                    end
                    chk($sformatf("wr%0d", wr_cnt), {busy, sha_address, sha_write_data}, {1'b1, ea, ed});
                    wr_cnt++;
                end
                if (sha_cs && !sha_we && sha_address == 8'h09) poll_cnt++;
                if (done || busy) chk("busy_done_excl", done && busy, 0);
            end
        end
    end

    task automatic wr_blk(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        blk_we = 1'b1; blk_addr = a; blk_wdata = d;
        @(posedge clk); #1;
        blk_we = 1'b0;
        mbuf[a] = d;
    endtask

    task automatic run_scan(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t,
                            input bit mode, input bit poke);
        m_start = s; m_mode = mode;
        nonce_start = s; nonce_end = e; target = t; mode_224 = mode;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (poke && i == 3) begin
                blk_we = 1'b1; blk_addr = 4'd5; blk_wdata = 32'hdeadbeef;
                start = 1'b1; nonce_start = 32'h12345678;
            end
            if (poke && i == 4) begin blk_we = 1'b0; start = 1'b0; end
            if (done) break;
            @(posedge clk); #1;
        end
        chk("scan_done", done, 1);
    endtask

    task automatic check_scan(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t, input bit mode);
        bit          mf;
        logic [31:0] mc, mcur;
        logic [255:0] md;
        model(s, e, t, mode, mf, mc, mcur, md);
        chk("found", found, mf);
        if (mf) chk("found_nonce", found_nonce, mcur);
        chk("hash_count", hash_count, mc);
        chk("cur_nonce", cur_nonce, mcur);
        chk("digest", digest_o, md);
        chk("busy_end", busy, 0);
        chk("writes", 32'(wr_cnt), 32'(17) * mc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {busy, done, found, timeout_err, sha_cs, sha_we}, 0);
        chk({tag, "_nonces"}, {cur_nonce, found_nonce, hash_count}, 0);
        chk({tag, "_digest"}, digest_o, 0);
        chk({tag, "_bus"}, {sha_address, sha_write_data}, 0);
    endtask

    initial begin
        logic [255:0] ref_d;
        bit           hit;
        reset_n = 1'b0; blk_we = 1'b0; blk_addr = '0; blk_wdata = '0; start = 1'b0; abort = 1'b0;
        mode_224 = 1'b0; nonce_start = '0; nonce_end = '0; target = '0;
        for (int k = 0; k < 16; k++) mbuf[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        reset_n = 1'b1;

        wr_blk(4'd0, 32'h61626380);
        wr_blk(4'd15, 32'h00000018);

        // Literal pins on the reference hash itself.
        ref_d = sha_ref(blk_with(32'h61626380), 1'b1);
        chk("model_abc256_w0", ref_d[255:224], 32'hba7816bf);
        ref_d = sha_ref(blk_with(32'h61626380), 1'b0);
        chk("model_abc224_w0", ref_d[255:224], 32'h23097d22);

        // "abc", SHA-256
        run_scan(32'h61626380, 32'h61626380, 32'hffffffff, 1'b0, 1'b0);
        check_scan(32'h61626380, 32'h61626380, 32'hffffffff, 1'b0);
        chk("abc_w0", digest_o[255:224], 32'hba7816bf);
        chk("abc_w7", digest_o[31:0], 32'hf20015ad);
        chk("abc_found", {found, found_nonce, hash_count}, {1'b1, 32'h61626380, 32'd1});
        chk("abc_ctrl", last_ctrl, 32'h5);

        // "abc", SHA-224
        run_scan(32'h61626380, 32'h61626380, 32'hffffffff, 1'b1, 1'b0);
        check_scan(32'h61626380, 32'h61626380, 32'hffffffff, 1'b1);
        chk("abc224_w0", digest_o[255:224], 32'h23097d22);
        chk("abc224_ctrl", last_ctrl, 32'h1);

        // Miss with wrap; blk_we and start poked mid-scan must be ignored
        run_scan(32'hfffffffe, 32'h00000001, 32'h0, 1'b0, 1'b1);
        check_scan(32'hfffffffe, 32'h00000001, 32'h0, 1'b0);
        chk("wrap_result", {done, found, hash_count, cur_nonce}, {1'b1, 1'b0, 32'd4, 32'd1});
        chk("wrap_ctrl_writes", 32'(wr_cnt / 17), 32'd4);

        // Abort during POLL of the second nonce
        m_start = 32'd10; m_mode = 1'b0;
        nonce_start = 32'd10; nonce_end = 32'd20; target = 32'h0; mode_224 = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (sha_cs && !sha_we && sha_address == 8'h09 && hash_count == 32'd1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_reach_poll2", hit, 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_state", {busy, sha_cs, done, found}, {1'b0, 1'b0, 1'b1, 1'b0});
        chk("abort_count", hash_count, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_writes", 32'(wr_cnt), 32'd34);
        run_scan(32'h61626380, 32'h61626380, 32'hffffffff, 1'b0, 1'b0);
        check_scan(32'h61626380, 32'h61626380, 32'hffffffff, 1'b0);

        // Timeout with valid stuck low
        stuck = 1'b1;
        run_scan(32'd5, 32'd5, 32'hffffffff, 1'b0, 1'b0);
        chk("to_flags", {timeout_err, done, busy, found}, {1'b1, 1'b1, 1'b0, 1'b0});
        chk("to_count", hash_count, 32'd0);
        chk("to_polls", 32'(poll_cnt), 32'd15);
        chk("to_writes", 32'(wr_cnt), 32'd17);
        stuck = 1'b0;

        // Reset pulse mid-LOAD clears everything including the block buffer
        m_start = 32'h61626380; m_mode = 1'b0;
        nonce_start = 32'h61626380; nonce_end = 32'h61626380; target = 32'hffffffff;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200 && wr_cnt < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_load", {busy, 32'(wr_cnt)}, {1'b1, 32'd5});
        reset_n = 1'b0;
        #1;
        chk_zero("rst_pulse");
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 16; k++) mbuf[k] = '0;
        run_scan(32'd7, 32'd7, 32'hffffffff, 1'b0, 1'b0);
        check_scan(32'd7, 32'd7, 32'hffffffff, 1'b0);
        chk("post_rst_found", {found, found_nonce}, {1'b1, 32'd7});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
